// File: rtl/add_share_sched_if.sv
// Requester-side bundle for add_share_sched: operand request channel and
// shared result channel, one valid/ready pair per requester.
interface add_share_sched_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_left;
    logic [NREQ*WIDTH-1:0] req_right;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_carry;

    modport master (
        output req_valid, req_left, req_right, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry
    );

    modport slave (
        input  req_valid, req_left, req_right, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry
    );
endinterface

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one adder and one result register among
// NREQ requesters: accept, add, then hold the response until consumed.
module add_share_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    add_share_sched_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt;
    logic [WIDTH-1:0] op_l;
    logic [WIDTH-1:0] op_r;
    logic [WIDTH:0]   res;
    logic [WIDTH:0]   sum_full;
    logic             found;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] gnt_next;
    int unsigned      cand;

    // Search order starts at ptr and wraps; first valid requester wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                gidx  = IDX_W'(cand);
            end
        end
    end

    // Gated by reset so no accept is advertised while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (!reset && state == S_IDLE && found)
            bus.req_ready[gidx] = 1'b1;
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state == S_RESP)
            bus.rsp_valid[gnt] = 1'b1;
    end

    assign bus.rsp_data  = res[WIDTH-1:0];
    assign bus.rsp_carry = res[WIDTH];
    assign sum_full      = {1'b0, op_l} + {1'b0, op_r};
    assign gnt_next      = (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            op_l     <= '0;
            op_r     <= '0;
            res      <= '0;
            op_count <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        op_l  <= bus.req_left[gidx*WIDTH +: WIDTH];
                        op_r  <= bus.req_right[gidx*WIDTH +: WIDTH];
                        gnt   <= gidx;
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    res   <= sum_full;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready[gnt]) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        ptr      <= gnt_next;
                        op_count <= op_count + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_share_sched.sv
// Randomized bench for add_share_sched against a transaction-level model
// of round-robin grant order, unsigned sum/carry and the wrapping op counter.
module tb_add_share_sched;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    add_share_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    add_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    int unsigned      m_ptr   = 0;
    int unsigned      m_cnt   = 0;
    logic [WIDTH-1:0] lft [NREQ];
    logic [WIDTH-1:0] rgt [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_left[i*WIDTH +: WIDTH]  = lft[i];
            bus.req_right[i*WIDTH +: WIDTH] = rgt[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < int'(NREQ); i++) begin
            lft[i] = $urandom;
            rgt[i] = $urandom;
        end
        drive_ops();
    endtask

    function automatic int pick(input logic [NREQ-1:0] mask);
        for (int unsigned k = 0; k < NREQ; k++)
            if (mask[(m_ptr + k) % NREQ]) return int'((m_ptr + k) % NREQ);
        return -1;
    endfunction

    // Entered just after a clock edge with the DUT idle; leaves it idle again.
    task automatic run_op(input logic [NREQ-1:0] mask, input int unsigned bp, input bit scr);
        int             g;
        logic [WIDTH:0] exp;
        logic [NREQ-1:0] gbit;
        bus.req_valid = mask;
        drive_ops();
        #1;
        g = pick(mask);
        if (g < 0) begin
            check("idle_ready", 64'(bus.req_ready), 64'(0));
            step();
            check("idle_busy", 64'(busy), 64'(0));
            return;
        end
        gbit = NREQ'(1) << g;
        check("accept_ready", 64'(bus.req_ready), 64'(gbit));
        exp = {1'b0, lft[g]} + {1'b0, rgt[g]};
        step();
        if (scr) scramble();
        #1;
        check("exec_busy", 64'(busy), 64'(1));
        check("exec_ready", 64'(bus.req_ready), 64'(0));
        check("exec_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        step();
        for (int unsigned b = 0; b < bp; b++) begin
            bus.rsp_ready = NREQ'($urandom) & ~gbit;
            if (scr) scramble();
            #1;
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(gbit));
            check("bp_data", 64'(bus.rsp_data), 64'(exp[WIDTH-1:0]));
            check("bp_carry", 64'(bus.rsp_carry), 64'(exp[WIDTH]));
            check("bp_ready", 64'(bus.req_ready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
            step();
        end
        bus.rsp_ready = gbit | NREQ'($urandom);
        #1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(gbit));
        check("rsp_data", 64'(bus.rsp_data), 64'(exp[WIDTH-1:0]));
        check("rsp_carry", 64'(bus.rsp_carry), 64'(exp[WIDTH]));
        step();
        bus.rsp_ready = '0;
        m_ptr = (int'(g) + 1) % NREQ;
        m_cnt++;
        check("done_busy", 64'(busy), 64'(0));
        check("op_count", 64'(op_count), 64'(m_cnt % (1 << CNT_W)));
    endtask

    task automatic rand_ops(input int unsigned n, input bit allow_idle);
        logic [NREQ-1:0] mask;
        for (int unsigned t = 0; t < n; t++) begin
            mask = NREQ'($urandom);
            if (!allow_idle && mask == '0) mask = NREQ'(1) << $urandom_range(NREQ - 1, 0);
            for (int i = 0; i < int'(NREQ); i++) begin
                case ($urandom_range(3, 0))
                    0:       begin lft[i] = '1; rgt[i] = $urandom; end
                    1:       begin lft[i] = '0; rgt[i] = '0; end
                    default: begin lft[i] = $urandom; rgt[i] = $urandom; end
                endcase
            end
            run_op(mask, $urandom_range(3, 0), 1'b1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        for (int i = 0; i < int'(NREQ); i++) begin lft[i] = '0; rgt[i] = '0; end
        drive_ops();
        #2;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_data", 64'(bus.rsp_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(op_count), 64'(0));
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        step();
        reset = 1'b0;

        // single op 5 + 7 from requester 0
        lft[0] = 32'd5; rgt[0] = 32'd7;
        run_op(4'b0001, 0, 1'b0);

        // overflow 0xFFFFFFFF + 2
        lft[1] = 32'hFFFF_FFFF; rgt[1] = 32'd2;
        run_op(4'b0010, 0, 1'b0);

        // fairness: everyone valid, operands (i, 10*i)
        m_ptr = 2;
        for (int i = 0; i < int'(NREQ); i++) begin
            lft[i] = WIDTH'(i);
            rgt[i] = WIDTH'(10 * i);
        end
        for (int t = 0; t < 8; t++) run_op('1, 0, 1'b0);

        // backpressure on req 2 with operand churn, then ptr must be 3
        lft[2] = 32'd100; rgt[2] = 32'd23;
        run_op(4'b0100, 5, 1'b1);
        for (int i = 0; i < int'(NREQ); i++) begin lft[i] = WIDTH'(i); rgt[i] = 32'd1; end
        run_op('1, 0, 1'b0);
        check("ptr_after_bp", 64'(m_ptr), 64'(0));

        // a few idle cycles must not move the pointer
        run_op('0, 0, 1'b0);
        run_op('0, 0, 1'b0);

        // reset asserted during EXEC, no clock edge needed to clear outputs
        lft[0] = 32'd9; rgt[0] = 32'd9;
        bus.req_valid = 4'b0101;
        drive_ops();
        #1;
        step();
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_data", 64'(bus.rsp_data), 64'(0));
        check("mid_rst_carry", 64'(bus.rsp_carry), 64'(0));
        check("mid_rst_count", 64'(op_count), 64'(0));
        bus.req_valid = 4'b1000;
        step();
        step();
        reset = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        #1;
        check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        lft[3] = 32'd40; rgt[3] = 32'd2;
        run_op(4'b1000, 0, 1'b0);

        // 16 more completions: 17 total wraps a 4-bit counter to 1
        rand_ops(16, 1'b0);
        check("wrap_count", 64'(op_count), 64'(1));

        rand_ops(40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
